// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter: serialises I-cache fills, D-cache fills and D-cache write-through stores
// onto the single pipelined memory port, and drives the fetch/memory-stage stall lines.
module cache_mem_arbiter #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16,
   parameter int WORDS  = 8,
   parameter int CNT_W  = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ic_miss,
   input  logic [ADDR_W-1:0] ic_addr,
   input  logic              dc_miss,
   input  logic              dc_wr,
   input  logic [ADDR_W-1:0] dc_addr,
   input  logic [DATA_W-1:0] dc_wdata,
   output logic              mem_en,
   output logic              mem_wr,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_rvalid,
   output logic [DATA_W-1:0] fill_data,
   output logic [CNT_W-1:0]  fill_word,
   output logic              ic_fill_we,
   output logic              dc_fill_we,
   output logic              ic_done,
   output logic              dc_done,
   output logic              stall_fetch,
   output logic              stall_mem
);
   localparam int BASE_W = ADDR_W - CNT_W - 1;

   typedef enum logic [1:0] {IDLE, WRITE, FILL, DONE} stateT;

   stateT             state, nextState;
   logic [CNT_W-1:0]  issueCnt, recvCnt;
   logic              issueDone, ownerDc, accept, lastWord;
   logic [BASE_W-1:0] base;
   logic [ADDR_W-1:0] storeAddr;
   logic [DATA_W-1:0] storeData;
   logic              unusedAddrBits;

   assign unusedAddrBits = ^ic_addr[ADDR_W-BASE_W-1:0];
   assign accept         = (state == FILL) && mem_rvalid;
   assign lastWord       = accept && (recvCnt == CNT_W'(WORDS - 1));
   assign stall_fetch    = ~rst & ic_miss & ~ic_done;
   assign stall_mem      = ~rst & (dc_miss | dc_wr) & ~dc_done;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         issueCnt  <= '0;
         recvCnt   <= '0;
         issueDone <= 1'b0;
         ownerDc   <= 1'b0;
         base      <= '0;
         storeAddr <= '0;
         storeData <= '0;
      end else begin
         state <= nextState;
         if (state == IDLE) begin
            issueCnt  <= '0;
            recvCnt   <= '0;
            issueDone <= 1'b0;
            // D side is checked first: it holds the older instruction
            if (dc_wr | dc_miss) begin
               ownerDc   <= 1'b1;
               base      <= dc_addr[ADDR_W-1 -: BASE_W];
               storeAddr <= dc_addr;
               storeData <= dc_wdata;
            end else if (ic_miss) begin
               ownerDc <= 1'b0;
               base    <= ic_addr[ADDR_W-1 -: BASE_W];
            end
         end else if (state == FILL) begin
            if (!issueDone) begin
               if (issueCnt == CNT_W'(WORDS - 1)) issueDone <= 1'b1;
               else issueCnt <= issueCnt + 1'b1;
            end
            if (accept && !lastWord) recvCnt <= recvCnt + 1'b1;
         end
      end
   end

   always_comb begin
      nextState  = state;
      mem_en     = 1'b0;
      mem_wr     = 1'b0;
      mem_addr   = '0;
      mem_wdata  = '0;
      fill_data  = accept ? mem_rdata : '0;
      fill_word  = accept ? recvCnt : '0;
      ic_fill_we = accept & ~ownerDc;
      dc_fill_we = accept & ownerDc;
      ic_done    = (state == DONE) & ~ownerDc;
      dc_done    = (state == DONE) & ownerDc;
      case (state)
         IDLE:  nextState = dc_wr ? WRITE : (dc_miss | ic_miss) ? FILL : IDLE;
         WRITE: begin
            nextState = DONE;
            mem_en    = 1'b1;
            mem_wr    = 1'b1;
            mem_addr  = storeAddr;
            mem_wdata = storeData;
         end
         FILL:  begin
            nextState = lastWord ? DONE : FILL;
            mem_en    = ~issueDone;
            mem_addr  = issueDone ? '0 : {base, issueCnt, 1'b0};
         end
         default: nextState = IDLE;
      endcase
   end
endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb_cache_mem_arbiter: directed tests against a transaction-level model of the arbiter,
// with a pipelined memory model (fixed 4-cycle or stretched latency).
module tb_cache_mem_arbiter;
   logic        clk = 1'b0, rst = 1'b1;
   logic        ic_miss = 1'b0, dc_miss = 1'b0, dc_wr = 1'b0;
   logic [15:0] ic_addr = '0, dc_addr = '0, dc_wdata = '0;
   logic        mem_en, mem_wr, mem_rvalid = 1'b0;
   logic [15:0] mem_addr, mem_wdata, mem_rdata = '0, fill_data;
   logic [2:0]  fill_word;
   logic        ic_fill_we, dc_fill_we, ic_done, dc_done, stall_fetch, stall_mem;

   always #5 clk = ~clk;

   cache_mem_arbiter dut (
      .clk(clk), .rst(rst), .ic_miss(ic_miss), .ic_addr(ic_addr), .dc_miss(dc_miss),
      .dc_wr(dc_wr), .dc_addr(dc_addr), .dc_wdata(dc_wdata), .mem_en(mem_en),
      .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .mem_rvalid(mem_rvalid), .fill_data(fill_data), .fill_word(fill_word),
      .ic_fill_we(ic_fill_we), .dc_fill_we(dc_fill_we), .ic_done(ic_done),
      .dc_done(dc_done), .stall_fetch(stall_fetch), .stall_mem(stall_mem)
   );

   int checks = 0, failures = 0, cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic logic [15:0] memData(input logic [15:0] a);
      return a ^ 16'h5A5A;
   endfunction

   // memory: reads return in order, no earlier than 4 cycles after issue
   typedef struct {logic [15:0] a; int due;} rdT;
   rdT rdQ[$];
   bit stretch = 0, spurIdle = 0;
   int spurAt = -1;
   initial begin
      int gap = 0;
      forever begin
         @(negedge clk);
         if (!rst && mem_en && !mem_wr) rdQ.push_back('{mem_addr, cyc + 4});
         @(posedge clk); #1;
         mem_rvalid = 1'b0;
         mem_rdata  = '0;
         if (spurIdle || cyc == spurAt) begin
            mem_rvalid = 1'b1;
            mem_rdata  = 16'hDEAD;
         end else if (gap > 0) gap--;
         else if (rdQ.size() > 0 && rdQ[0].due <= cyc) begin
            mem_rvalid = 1'b1;
            mem_rdata  = memData(rdQ[0].a);
            void'(rdQ.pop_front());
            if (stretch) gap = $urandom_range(0, 3);
         end
      end
   end

   // transaction-level model: grant by priority, then fixed schedule relative to the grant cycle
   bit          mBusy = 0, mStore = 0, mOwnDc = 0;
   logic [11:0] mBase;
   logic [15:0] mSAddr, mSData;
   int          mStart, mRecv, mDoneAt;
   int          fillCyc[$], fillWord[$], fillDat[$], icDoneQ[$], dcDoneQ[$], issueQ[$];
   int          writeA[$], writeD[$], writeCyc[$];
   int          stallCnt = 0, overlap = 0;

   always @(negedge clk) begin
      logic        eEn, eWr, eIcWe, eDcWe, eIcDone, eDcDone;
      logic [15:0] eAddr, eWdata;
      int          k;
      eEn = 0; eWr = 0; eIcWe = 0; eDcWe = 0; eIcDone = 0; eDcDone = 0;
      eAddr = '0; eWdata = '0;
      if (rst) mBusy = 0;
      else if (!mBusy) begin
         if (dc_wr || dc_miss || ic_miss) begin
            mBusy = 1; mStart = cyc; mStore = dc_wr; mOwnDc = dc_wr || dc_miss;
            mBase = mOwnDc ? dc_addr[15:4] : ic_addr[15:4];
            mSAddr = dc_addr; mSData = dc_wdata; mRecv = 0; mDoneAt = -1;
         end
      end else begin
         k = cyc - mStart;
         if (mStore) begin
            if (k == 1) begin eEn = 1; eWr = 1; eAddr = mSAddr; eWdata = mSData; end
            else begin eDcDone = 1; mBusy = 0; end
         end else begin
            if (k >= 1 && k <= 8) begin eEn = 1; eAddr = {mBase, 4'(2 * (k - 1))}; end
            if (cyc == mDoneAt) begin
               eIcDone = !mOwnDc; eDcDone = mOwnDc; mBusy = 0;
            end else if (mem_rvalid && mRecv < 8) begin
               eIcWe = !mOwnDc; eDcWe = mOwnDc;
               chk("fill_word", fill_word, mRecv);
               chk("fill_data", fill_data, memData({mBase, 4'(2 * mRecv)}));
               mRecv++;
               if (mRecv == 8) mDoneAt = cyc + 1;
            end
         end
      end
      chk("mem_en", mem_en, eEn);
      if (eEn) begin chk("mem_wr", mem_wr, eWr); chk("mem_addr", mem_addr, eAddr); end
      if (eWr) chk("mem_wdata", mem_wdata, eWdata);
      chk("ic_fill_we", ic_fill_we, eIcWe);
      chk("dc_fill_we", dc_fill_we, eDcWe);
      chk("ic_done", ic_done, eIcDone);
      chk("dc_done", dc_done, eDcDone);
      chk("stall_fetch", stall_fetch, !rst && ic_miss && !eIcDone);
      chk("stall_mem", stall_mem, !rst && (dc_miss || dc_wr) && !eDcDone);
      if (ic_fill_we || dc_fill_we) begin
         fillCyc.push_back(cyc); fillWord.push_back(int'(fill_word)); fillDat.push_back(int'(fill_data));
      end
      if (ic_fill_we && dc_fill_we) overlap++;
      if (ic_done) icDoneQ.push_back(cyc);
      if (dc_done) dcDoneQ.push_back(cyc);
      if (mem_en && !mem_wr) issueQ.push_back(int'(mem_addr));
      if (mem_en && mem_wr) begin
         writeA.push_back(int'(mem_addr)); writeD.push_back(int'(mem_wdata)); writeCyc.push_back(cyc);
      end
      if (stall_fetch) stallCnt++;
   end

   // cache behaviour: drop the request answered by a done pulse; a store is always the one answered first
   task automatic runQuiet(input int budget);
      bit quiet = 0, dI, dD;
      for (int i = 0; i < budget && !quiet; i++) begin
         @(negedge clk); #1;
         dI = ic_done; dD = dc_done;
         quiet = !mBusy && !ic_miss && !dc_miss && !dc_wr;
         @(posedge clk); #1;
         if (dI) ic_miss = 0;
         if (dD) begin
            if (dc_wr) dc_wr = 0;
            else dc_miss = 0;
         end
      end
      chk("quiet_within_budget", quiet, 1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int t0, f0, i0, d0, w0, s0, n0;
      ic_miss = 1;
      #12;
      chk("rst_stall_fetch", stall_fetch, 0);
      chk("rst_mem_en", mem_en, 0);
      chk("rst_ic_done", ic_done, 0);
      @(posedge clk); #1;
      rst = 0; ic_miss = 0;
      repeat (2) @(posedge clk);
      #1;

      // I fill, 4-cycle memory, spurious rvalid in DONE
      f0 = fillCyc.size(); i0 = issueQ.size(); s0 = stallCnt; n0 = icDoneQ.size();
      ic_addr = 16'h1236; ic_miss = 1; t0 = cyc; spurAt = t0 + 13;
      runQuiet(40);
      chk("t1_issue_first", issueQ[i0], 16'h1230);
      chk("t1_issue_last", issueQ[i0+7], 16'h123E);
      chk("t1_issue_count", issueQ.size() - i0, 8);
      chk("t1_fill_first_cyc", fillCyc[f0] - t0, 5);
      chk("t1_fill_last_cyc", fillCyc[f0+7] - t0, 12);
      chk("t1_fill_count", fillCyc.size() - f0, 8);
      chk("t1_word0_data", fillDat[f0], 16'h486A);
      chk("t1_done_cyc", icDoneQ[n0] - t0, 13);
      chk("t1_stall_cycles", stallCnt - s0, 13);
      spurAt = -1;

      // simultaneous I and D misses: D served first
      i0 = issueQ.size(); n0 = icDoneQ.size(); d0 = dcDoneQ.size();
      ic_addr = 16'h1236; dc_addr = 16'h4000; ic_miss = 1; dc_miss = 1; t0 = cyc;
      runQuiet(60);
      chk("t2_dc_first_addr", issueQ[i0], 16'h4000);
      chk("t2_ic_first_addr", issueQ[i0+8], 16'h1230);
      chk("t2_dc_done_cyc", dcDoneQ[d0] - t0, 13);
      chk("t2_ic_done_cyc", icDoneQ[n0] - t0, 27);
      chk("t2_no_overlap", overlap, 0);

      // store and miss together: store first, then fill of the same block
      i0 = issueQ.size(); d0 = dcDoneQ.size(); w0 = writeA.size();
      dc_addr = 16'h0102; dc_wdata = 16'hBEEF; dc_wr = 1; dc_miss = 1; t0 = cyc;
      runQuiet(60);
      chk("t3_write_addr", writeA[w0], 16'h0102);
      chk("t3_write_data", writeD[w0], 16'hBEEF);
      chk("t3_write_cyc", writeCyc[w0] - t0, 1);
      chk("t3_store_done_cyc", dcDoneQ[d0] - t0, 2);
      chk("t3_fill_done_cyc", dcDoneQ[d0+1] - t0, 16);
      chk("t3_fill_addr", issueQ[i0], 16'h0100);

      // stretched memory latency
      f0 = fillCyc.size(); d0 = dcDoneQ.size();
      stretch = 1; dc_addr = 16'h2468; dc_miss = 1;
      runQuiet(100);
      stretch = 0;
      chk("t4_fill_count", fillCyc.size() - f0, 8);
      for (int i = 0; i < 8; i++) chk("t4_word_order", fillWord[f0+i], i);
      chk("t4_word3_data", fillDat[f0+3], 16'h7E3C);
      chk("t4_done_after_last", dcDoneQ[d0] - fillCyc[f0+7], 1);

      // async reset in the middle of an I fill
      f0 = fillCyc.size();
      ic_addr = 16'h3000; ic_miss = 1; t0 = cyc;
      while (cyc != t0 + 6) begin @(posedge clk); #1; end
      rst = 1; #1;
      chk("t5_rst_mem_en", mem_en, 0);
      chk("t5_rst_mem_addr", mem_addr, 0);
      chk("t5_rst_fill_we", ic_fill_we, 0);
      chk("t5_rst_stall", stall_fetch, 0);
      repeat (3) @(posedge clk);
      #1;
      rst = 0; ic_miss = 0;
      repeat (5) @(posedge clk);
      #1;
      chk("t5_fills_before_rst_only", fillCyc.size() - f0, 1);
      f0 = fillCyc.size(); n0 = icDoneQ.size();
      ic_miss = 1; t0 = cyc;
      runQuiet(40);
      chk("t5_restart_word0", fillWord[f0], 0);
      chk("t5_restart_data0", fillDat[f0], 16'h6A5A);
      chk("t5_restart_done_cyc", icDoneQ[n0] - t0, 13);

      // spurious rvalid while idle
      f0 = fillCyc.size();
      spurIdle = 1;
      repeat (3) @(posedge clk);
      #1;
      spurIdle = 0;
      repeat (2) @(posedge clk);
      #1;
      chk("t6_idle_no_fill", fillCyc.size() - f0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
